// File: rtl/counter_pkg.sv
// Shared mode codes, checker state encoding and saturating-counter helper.
package counter_pkg;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_CHECK  = 2'b01,
        ST_HALTED = 2'b10
    } chk_state_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// Counter-side signals observed by the checker.
// There is no valid/ready pair: the bus is sampled on every rising CLK edge,
// every edge is one transaction, and the consumer never applies backpressure.
interface counter_checker_if #(
    parameter int WIDTH = 4
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q_DUT;
    logic             RCO_DUT;

    modport master (output ENB, MODO, D, Q_DUT, RCO_DUT);
    modport slave  (input  ENB, MODO, D, Q_DUT, RCO_DUT);
endinterface

// File: rtl/counter_ref_model.sv
// Registered reference model of the modal counter; SEED_EN replaces the
// current count with SEED_Q as the base of this edge's update.
module counter_ref_model
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic             SEED_EN,
    input  logic [WIDTH-1:0] SEED_Q,
    output logic [WIDTH-1:0] Q_EXP,
    output logic             RCO_EXP
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0] ALL1  = '1;

    logic [WIDTH-1:0] q_q, q_d, base;
    logic             rco_q, rco_d;

    // Next count and carry from the selected base value and the sampled mode.
    always_comb begin
        base  = SEED_EN ? SEED_Q : q_q;
        q_d   = '0;
        rco_d = 1'b0;
        if (ENB) begin
            case (MODO)
                MODE_UP: begin
                    q_d   = base + ONE;
                    rco_d = (base == ALL1);
                end
                MODE_DOWN: begin
                    q_d   = base - ONE;
                    rco_d = (base == '0);
                end
                MODE_DOWN3: begin
                    q_d   = base - THREE;
                    rco_d = (base < THREE);
                end
                default: begin
                    q_d   = D;
                    rco_d = 1'b0;
                end
            endcase
        end
    end

    // Model registers, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign Q_EXP   = q_q;
    assign RCO_EXP = rco_q;

endmodule

// File: rtl/counter_checker.sv
// Cycle-accurate checker for the modal counter: sync FSM, comparator and
// saturating statistics around a registered reference model.
module counter_checker
    import counter_pkg::*;
#(
    parameter int          WIDTH         = 4,
    parameter logic [15:0] MAX_ERR       = 16'hFFFF,
    parameter bit          RESYNC_ON_ERR = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    counter_checker_if.slave bus,
    output logic [WIDTH-1:0] Q_EXP,
    output logic             RCO_EXP,
    output logic             SYNCED,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [15:0]      ERR_COUNT,
    output logic [15:0]      CHECK_COUNT,
    output logic [WIDTH-1:0] FIRST_ERR_Q,
    output logic             HALTED,
    output chk_state_e       STATE_DBG
);

    chk_state_e       state_q, state_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      chk_cnt_q, chk_cnt_d;
    logic [WIDTH-1:0] first_q, first_d;

    logic [WIDTH-1:0] q_exp;
    logic             rco_exp;
    logic             compare, q_mis, rco_mis, mismatch, seed_en;

    // Compare only while in CHECK; a Q mismatch may reseed the model so that a
    // corrupted counter state costs a single error rather than a cascade.
    assign compare  = (state_q == ST_CHECK);
    assign q_mis    = compare && (bus.Q_DUT != q_exp);
    assign rco_mis  = compare && (bus.RCO_DUT != rco_exp);
    assign mismatch = q_mis || rco_mis;
    assign seed_en  = RESYNC_ON_ERR && q_mis;

    counter_ref_model #(.WIDTH(WIDTH)) u_ref (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENB     (bus.ENB),
        .MODO    (bus.MODO),
        .D       (bus.D),
        .SEED_EN (seed_en),
        .SEED_Q  (bus.Q_DUT),
        .Q_EXP   (q_exp),
        .RCO_EXP (rco_exp)
    );

    // Next state and statistics; HALTED freezes everything but the model.
    // The mismatch that reaches MAX_ERR is still pulsed on ERR and counted.
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        chk_cnt_d = chk_cnt_q;
        first_d   = first_q;
        case (state_q)
            ST_UNSYNC: begin
                // ENB=0 or a load makes the model value certain at this edge.
                if (!bus.ENB || (bus.MODO == MODE_LOAD)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                chk_cnt_d = sat_inc(chk_cnt_q);
                if (mismatch) begin
                    err_d     = 1'b1;
                    sticky_d  = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (!sticky_q) begin
                        first_d = bus.Q_DUT;
                    end
                    if ((MAX_ERR != 16'd0) && (err_cnt_q == MAX_ERR - 16'd1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_UNSYNC;
            end
        endcase
    end

    // State and statistics registers, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_UNSYNC;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= 16'd0;
            chk_cnt_q <= 16'd0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
            chk_cnt_q <= chk_cnt_d;
            first_q   <= first_d;
        end
    end

    assign Q_EXP       = q_exp;
    assign RCO_EXP     = rco_exp;
    assign SYNCED      = (state_q != ST_UNSYNC);
    assign ERR         = err_q;
    assign ERR_STICKY  = sticky_q;
    assign ERR_COUNT   = err_cnt_q;
    assign CHECK_COUNT = chk_cnt_q;
    assign FIRST_ERR_Q = first_q;
    assign HALTED      = (state_q == ST_HALTED);
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: emulates a counter (with fault injection) and
// checks every checker output against a behavioural model each cycle.
module tb_counter_checker;
    import counter_pkg::*;

    // Clock and resets
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1, rst_h = 1'b1, rst_w = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    counter_checker_if #(.WIDTH(4))  bus_a ();
    counter_checker_if #(.WIDTH(4))  bus_h ();
    counter_checker_if #(.WIDTH(16)) bus_w ();

    logic [3:0]  a_q, a_feq, h_q, h_feq;
    logic [15:0] w_q, w_feq;
    logic        a_rco, a_syn, a_err, a_stk, a_hlt;
    logic        h_rco, h_syn, h_err, h_stk, h_hlt;
    logic        w_rco, w_syn, w_err, w_stk, w_hlt;
    logic [15:0] a_ec, a_cc, h_ec, h_cc, w_ec, w_cc;
    chk_state_e  a_st, h_st, w_st;

    counter_checker #(.WIDTH(4)) dut_a (
        .CLK(clk), .RESET(rst_a), .bus(bus_a),
        .Q_EXP(a_q), .RCO_EXP(a_rco), .SYNCED(a_syn), .ERR(a_err), .ERR_STICKY(a_stk),
        .ERR_COUNT(a_ec), .CHECK_COUNT(a_cc), .FIRST_ERR_Q(a_feq), .HALTED(a_hlt), .STATE_DBG(a_st)
    );
    counter_checker #(.WIDTH(4), .MAX_ERR(16'd3)) dut_h (
        .CLK(clk), .RESET(rst_h), .bus(bus_h),
        .Q_EXP(h_q), .RCO_EXP(h_rco), .SYNCED(h_syn), .ERR(h_err), .ERR_STICKY(h_stk),
        .ERR_COUNT(h_ec), .CHECK_COUNT(h_cc), .FIRST_ERR_Q(h_feq), .HALTED(h_hlt), .STATE_DBG(h_st)
    );
    counter_checker #(.WIDTH(16)) dut_w (
        .CLK(clk), .RESET(rst_w), .bus(bus_w),
        .Q_EXP(w_q), .RCO_EXP(w_rco), .SYNCED(w_syn), .ERR(w_err), .ERR_STICKY(w_stk),
        .ERR_COUNT(w_ec), .CHECK_COUNT(w_cc), .FIRST_ERR_Q(w_feq), .HALTED(w_hlt), .STATE_DBG(w_st)
    );

    // Behavioural checker model: mode 0 = not synced, 1 = comparing, 2 = halted.
    typedef struct packed {
        int m; int rco; int mode; int err; int sticky; int ec; int cc; int feq;
    } mdl_t;

    mdl_t ma, mh;
    int   cnt_a = 0, crco_a = 0, cnt_h = 0, crco_h = 0, cnt_w = 0, crco_w = 0;

    // Counter rules with plain modular arithmetic.
    function automatic void ctr_step(input int w, input int c, input logic enb, input logic [1:0] modo,
                                     input int d, output int nc, output int nr);
        int lim;
        lim = 1 << w;
        nc  = 0;
        nr  = 0;
        if (enb) begin
            case (modo)
                2'd0: begin nc = (c + 1) % lim;       nr = (c == lim - 1) ? 1 : 0; end
                2'd1: begin nc = (c + lim - 1) % lim; nr = (c == 0) ? 1 : 0;       end
                2'd2: begin nc = (c + lim - 3) % lim; nr = (c < 3) ? 1 : 0;        end
                default: begin nc = d; nr = 0; end
            endcase
        end
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s, input int w, input int max_err, input logic rst,
                                      input logic enb, input logic [1:0] modo, input int d,
                                      input int qd, input int rd);
        mdl_t n;
        int   base, nm, nr;
        bit   cmp, qmis, mis;
        n = '0;
        if (rst) return n;
        n     = s;
        n.err = 0;
        cmp   = (s.mode == 1);
        qmis  = cmp && (qd != s.m);
        mis   = qmis || (cmp && (rd != s.rco));
        base  = qmis ? qd : s.m;
        ctr_step(w, base, enb, modo, d, nm, nr);
        n.m   = nm;
        n.rco = nr;
        if (cmp) begin
            n.cc = (s.cc < 65535) ? s.cc + 1 : 65535;
            if (mis) begin
                n.err    = 1;
                n.sticky = 1;
                if (s.sticky == 0) n.feq = qd;
                n.ec = (s.ec < 65535) ? s.ec + 1 : 65535;
                if (max_err != 0 && s.ec + 1 == max_err) n.mode = 2;
            end
        end else if (s.mode == 0 && (!enb || modo == 2'd3)) begin
            n.mode = 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input mdl_t s, input logic [31:0] q, input logic rco,
                             input logic syn, input logic err, input logic stk, input logic [15:0] ec,
                             input logic [15:0] cc, input logic [31:0] feq, input logic hlt);
        chk({tag, ".q_exp"}, q, s.m);
        chk({tag, ".rco_exp"}, {31'd0, rco}, s.rco);
        chk({tag, ".synced"}, {31'd0, syn}, (s.mode != 0) ? 1 : 0);
        chk({tag, ".err"}, {31'd0, err}, s.err);
        chk({tag, ".sticky"}, {31'd0, stk}, s.sticky);
        chk({tag, ".err_count"}, {16'd0, ec}, s.ec);
        chk({tag, ".check_count"}, {16'd0, cc}, s.cc);
        chk({tag, ".first_err_q"}, feq, s.feq);
        chk({tag, ".halted"}, {31'd0, hlt}, (s.mode == 2) ? 1 : 0);
    endtask

    // Driver for the default checker; glitch >= 0 corrupts the counter state.
    task automatic step_a(input string tag, input logic rst, input logic enb, input logic [1:0] modo,
                          input logic [3:0] d, input int glitch, input bit flip);
        logic rd;
        if (glitch >= 0) cnt_a = glitch;
        rd = (crco_a != 0) ^ flip;
        rst_a = rst; bus_a.ENB = enb; bus_a.MODO = modo; bus_a.D = d;
        bus_a.Q_DUT = 4'(cnt_a); bus_a.RCO_DUT = rd;
        @(posedge clk); #1;
        ma = mdl_next(ma, 4, 16'hFFFF, rst, enb, modo, int'(d), cnt_a, rd ? 1 : 0);
        if (rst) begin cnt_a = 0; crco_a = 0; end
        else ctr_step(4, cnt_a, enb, modo, int'(d), cnt_a, crco_a);
        check_all(tag, ma, {28'd0, a_q}, a_rco, a_syn, a_err, a_stk, a_ec, a_cc, {28'd0, a_feq}, a_hlt);
    endtask

    // Driver for the MAX_ERR=3 checker with RCO_DUT stuck high.
    task automatic step_h(input string tag, input logic rst, input logic [1:0] modo, input logic [3:0] d);
        rst_h = rst; bus_h.ENB = 1'b1; bus_h.MODO = modo; bus_h.D = d;
        bus_h.Q_DUT = 4'(cnt_h); bus_h.RCO_DUT = 1'b1;
        @(posedge clk); #1;
        mh = mdl_next(mh, 4, 3, rst, 1'b1, modo, int'(d), cnt_h, 1);
        if (rst) begin cnt_h = 0; crco_h = 0; end
        else ctr_step(4, cnt_h, 1'b1, modo, int'(d), cnt_h, crco_h);
        check_all(tag, mh, {28'd0, h_q}, h_rco, h_syn, h_err, h_stk, h_ec, h_cc, {28'd0, h_feq}, h_hlt);
    endtask

    // Driver for the 16-bit checker with a fault-free counter.
    task automatic step_w(input logic rst, input logic [1:0] modo, input logic [15:0] d);
        rst_w = rst; bus_w.ENB = 1'b1; bus_w.MODO = modo; bus_w.D = d;
        bus_w.Q_DUT = 16'(cnt_w); bus_w.RCO_DUT = (crco_w != 0);
        @(posedge clk); #1;
        if (rst) begin cnt_w = 0; crco_w = 0; end
        else ctr_step(16, cnt_w, 1'b1, modo, int'(d), cnt_w, crco_w);
    endtask

    initial begin
        ma = '0;
        mh = '0;
        bus_a.ENB = 1'b0; bus_a.MODO = 2'd0; bus_a.D = '0; bus_a.Q_DUT = '0; bus_a.RCO_DUT = 1'b0;
        bus_h.ENB = 1'b0; bus_h.MODO = 2'd0; bus_h.D = '0; bus_h.Q_DUT = '0; bus_h.RCO_DUT = 1'b0;
        bus_w.ENB = 1'b0; bus_w.MODO = 2'd0; bus_w.D = '0; bus_w.Q_DUT = '0; bus_w.RCO_DUT = 1'b0;

        // Reset and synchronisation
        step_a("reset", 1'b1, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("reset_cc", {16'd0, a_cc}, 0);
        for (int i = 0; i < 3; i++) step_a("unsync", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("unsync_synced", {31'd0, a_syn}, 0);
        chk("unsync_cc", {16'd0, a_cc}, 0);
        step_a("sync_load", 1'b0, 1'b1, MODE_LOAD, 4'hC, -1, 1'b0);
        chk("sync_synced", {31'd0, a_syn}, 1);
        chk("sync_q", {28'd0, a_q}, 'hC);
        chk("sync_cc", {16'd0, a_cc}, 0);
        step_a("first_cmp", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("first_cmp_cc", {16'd0, a_cc}, 1);
        chk("first_cmp_err", {31'd0, a_err}, 0);

        // Up count across the wrap
        step_a("upw_rst", 1'b1, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        step_a("upw_load", 1'b0, 1'b1, MODE_LOAD, 4'hE, -1, 1'b0);
        chk("upw_q0", {28'd0, a_q}, 'hE);
        step_a("upw1", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("upw_q1", {28'd0, a_q}, 'hF); chk("upw_r1", {31'd0, a_rco}, 0);
        step_a("upw2", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("upw_q2", {28'd0, a_q}, 'h0); chk("upw_r2", {31'd0, a_rco}, 1);
        step_a("upw3", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("upw_q3", {28'd0, a_q}, 'h1); chk("upw_r3", {31'd0, a_rco}, 0);
        step_a("upw4", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("upw_cc", {16'd0, a_cc}, 4); chk("upw_ec", {16'd0, a_ec}, 0);

        // Down-by-3 across the wrap
        step_a("dn3_load", 1'b0, 1'b1, MODE_LOAD, 4'h4, -1, 1'b0);
        step_a("dn3_1", 1'b0, 1'b1, MODE_DOWN3, 4'h0, -1, 1'b0);
        chk("dn3_q1", {28'd0, a_q}, 'h1); chk("dn3_r1", {31'd0, a_rco}, 0);
        step_a("dn3_2", 1'b0, 1'b1, MODE_DOWN3, 4'h0, -1, 1'b0);
        chk("dn3_q2", {28'd0, a_q}, 'hE); chk("dn3_r2", {31'd0, a_rco}, 1);
        step_a("dn3_3", 1'b0, 1'b1, MODE_DOWN3, 4'h0, -1, 1'b0);
        chk("dn3_q3", {28'd0, a_q}, 'hB); chk("dn3_r3", {31'd0, a_rco}, 0);

        // Single corrupted count: Q_DUT=5 where the model holds 3
        step_a("flt_rst", 1'b1, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        step_a("flt_load", 1'b0, 1'b1, MODE_LOAD, 4'h1, -1, 1'b0);
        step_a("flt_up1", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        step_a("flt_up2", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("flt_qexp", {28'd0, a_q}, 3);
        step_a("flt_hit", 1'b0, 1'b1, MODE_UP, 4'h0, 5, 1'b0);
        chk("flt_err", {31'd0, a_err}, 1);
        chk("flt_ec", {16'd0, a_ec}, 1);
        chk("flt_feq", {28'd0, a_feq}, 5);
        for (int i = 0; i < 3; i++) step_a("flt_after", 1'b0, 1'b1, MODE_UP, 4'h0, -1, 1'b0);
        chk("flt_after_err", {31'd0, a_err}, 0);
        chk("flt_after_ec", {16'd0, a_ec}, 1);

        // Enable drop clears the count
        step_a("enb_drop", 1'b0, 1'b0, MODE_UP, 4'h0, -1, 1'b0);
        chk("enb_drop_q", {28'd0, a_q}, 0);
        chk("enb_drop_r", {31'd0, a_rco}, 0);

        // Randomised traffic with occasional faults and resets
        for (int i = 0; i < 400; i++) begin
            logic       r_rst, r_enb;
            logic [1:0] r_modo;
            logic [3:0] r_d;
            int         r_g;
            bit         r_f;
            r_rst  = ($urandom_range(0, 149) == 0);
            r_enb  = ($urandom_range(0, 7) != 0);
            r_modo = 2'($urandom_range(0, 3));
            r_d    = 4'($urandom_range(0, 15));
            r_g    = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 15)) : -1;
            r_f    = ($urandom_range(0, 24) == 0);
            step_a("rand", r_rst, r_enb, r_modo, r_d, r_g, r_f);
        end

        // Halt after MAX_ERR=3 mismatches, then reset mid-run
        step_h("h_rst", 1'b1, MODE_UP, 4'h0);
        step_h("h_load", 1'b0, MODE_LOAD, 4'h0);
        for (int i = 0; i < 3; i++) step_h("h_err", 1'b0, MODE_UP, 4'h0);
        chk("h_halted", {31'd0, h_hlt}, 1);
        chk("h_ec3", {16'd0, h_ec}, 3);
        for (int i = 0; i < 4; i++) step_h("h_frozen", 1'b0, MODE_UP, 4'h0);
        chk("h_ec_hold", {16'd0, h_ec}, 3);
        chk("h_err_low", {31'd0, h_err}, 0);
        chk("h_cc_hold", {16'd0, h_cc}, 3);
        step_h("h_reset", 1'b1, MODE_UP, 4'h0);
        chk("h_reset_hlt", {31'd0, h_hlt}, 0);
        chk("h_reset_ec", {16'd0, h_ec}, 0);
        chk("h_reset_syn", {31'd0, h_syn}, 0);
        chk("h_reset_stk", {31'd0, h_stk}, 0);

        // 16-bit cascade: 70000 up-counts saturate CHECK_COUNT
        step_w(1'b1, MODE_UP, 16'h0);
        step_w(1'b0, MODE_LOAD, 16'h0);
        for (int i = 0; i < 70000; i++) step_w(1'b0, MODE_UP, 16'h0);
        chk("w_cc_sat", {16'd0, w_cc}, 'hFFFF);
        chk("w_ec", {16'd0, w_ec}, 0);
        chk("w_q", {16'd0, w_q}, 70000 % 65536);
        chk("w_stk", {31'd0, w_stk}, 0);
        chk("w_hlt", {31'd0, w_hlt}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
